k_vector_loader: RTL

- Producer (write) side of the K-vector FIFO.
- Sits in the memory controller and fetches the K matrix from memory as 64-bit beats.
- Assembles each row into one K_VECTOR_T and pushes it into the K FIFO over the write_enable / sram_ready handshake.
- Loads num_rows rows per start command, then pulses done.

---
 rtl/k_vector_loader_pkg.sv | 23 ++
 rtl/k_vector_loader_assembler.sv | 45 ++++
 rtl/k_vector_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/k_vector_loader_pkg.sv
// Shared types and geometry for the K-vector loader.
// No logic; constants and types only.
// Backpressure: n/a.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 16
`endif

package k_vector_loader_pkg;
    localparam int MAX_SEQ_LENGTH = `MAX_SEQ_LENGTH;
    localparam int HEAD_DIM       = 64;
    localparam int BEAT_BYTES     = 8;
    localparam int BEATS_PER_ROW  = HEAD_DIM / BEAT_BYTES;
    localparam int BEAT_W         = 8 * BEAT_BYTES;

    // Element i of a row is byte i in memory; element 0 sits in the low bits.
    typedef logic [HEAD_DIM-1:0][7:0] K_VECTOR_T;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } loader_state_t;
endpackage

// File: rtl/k_vector_loader_assembler.sv
// Collects BEATS_PER_ROW response beats into one K row and flags it full.
// Latency: asm_full rises the cycle after the final beat.
// Backpressure: none on beats; row stays full until consume.
module k_beat_assembler
    import k_vector_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat_vld,
    input  logic [BEAT_W-1:0] beat_dat,
    input  logic              consume,
    output logic              asm_full,
    output K_VECTOR_T         asm_data
);
    localparam int CNT_W = $clog2(BEATS_PER_ROW);

    logic [CNT_W-1:0]                       beat_cnt;
    logic [BEATS_PER_ROW-1:0][BEAT_W-1:0]   beat_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            beat_buf <= '0;
            asm_full <= 1'b0;
        end else if (clear) begin
            beat_cnt <= '0;
            asm_full <= 1'b0;
        end else begin
            if (consume)
                asm_full <= 1'b0;
            if (beat_vld) begin
                beat_buf[beat_cnt] <= beat_dat;
                if (beat_cnt == CNT_W'(BEATS_PER_ROW - 1)) begin
                    beat_cnt <= '0;
                    asm_full <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign asm_data = K_VECTOR_T'(beat_buf);
endmodule

// File: rtl/k_vector_loader.sv
// Fetches num_rows K rows as 64-bit beats and pushes each assembled row into the K FIFO.
// Latency: last beat at t, write_enable at t+2; done the cycle after the last accepted write.
// Backpressure: sram_ready stalls hold; a full assembly buffer stops further requests.
module k_vector_loader
    import k_vector_loader_pkg::*;
#(
    parameter  int NUM_ROWS = MAX_SEQ_LENGTH,
    parameter  int ADDR_W   = 32,
    localparam int RW       = $clog2(NUM_ROWS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [RW-1:0]     num_rows,
    output logic              busy,
    output logic              done,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [BEAT_W-1:0] mem_resp_data,
    output logic              write_enable,
    output K_VECTOR_T         write_data,
    input  logic              sram_ready
);
    localparam int BW = $clog2(BEATS_PER_ROW) + 1;

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [RW-1:0]     rows_q;
    logic [RW-1:0]     row_req_q;
    logic [BW-1:0]     beat_req_q;
    logic [RW-1:0]     rows_wr_q;
    logic              hold_vld_q;
    K_VECTOR_T         hold_q;

    logic              asm_full;
    K_VECTOR_T         asm_data;
    logic              req_fire, wr_fire, move;
    logic [RW-1:0]     rows_clamped;
    logic [ADDR_W-1:0] req_addr;

    assign rows_clamped = (num_rows > RW'(NUM_ROWS)) ? RW'(NUM_ROWS) : num_rows;

    // Only one row is requested at a time, so outstanding beats never exceed one row.
    assign mem_req_valid = (state_q == ST_FETCH) && (row_req_q < rows_q) && !asm_full
                           && (beat_req_q < BW'(BEATS_PER_ROW));
    assign req_addr      = base_q + ADDR_W'(row_req_q) * ADDR_W'(HEAD_DIM)
                                  + ADDR_W'(beat_req_q) * ADDR_W'(BEAT_BYTES);
    assign mem_req_addr  = mem_req_valid ? req_addr : '0;

    assign req_fire     = mem_req_valid && mem_req_ready;
    assign wr_fire      = hold_vld_q && sram_ready;
    assign move         = asm_full && (!hold_vld_q || sram_ready);

    assign busy         = (state_q == ST_FETCH);
    assign done         = (state_q == ST_DONE);
    assign write_enable = hold_vld_q;
    assign write_data   = hold_q;

    k_beat_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != ST_FETCH),
        .beat_vld (mem_resp_valid && (state_q == ST_FETCH)),
        .beat_dat (mem_resp_data),
        .consume  (move),
        .asm_full (asm_full),
        .asm_data (asm_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (num_rows == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (wr_fire && (rows_wr_q + RW'(1) == rows_q)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            rows_q     <= '0;
            row_req_q  <= '0;
            beat_req_q <= '0;
            rows_wr_q  <= '0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                base_q     <= base_addr;
                rows_q     <= rows_clamped;
                row_req_q  <= '0;
                beat_req_q <= '0;
                rows_wr_q  <= '0;
                hold_vld_q <= 1'b0;
            end else if (state_q == ST_FETCH) begin
                // move and req_fire are exclusive: requests need an empty assembly buffer.
                if (move) begin
                    row_req_q  <= row_req_q + RW'(1);
                    beat_req_q <= '0;
                end else if (req_fire) begin
                    beat_req_q <= beat_req_q + BW'(1);
                end
                if (move) begin
                    hold_q     <= asm_data;
                    hold_vld_q <= 1'b1;
                end else if (wr_fire) begin
                    hold_vld_q <= 1'b0;
                end
                if (wr_fire)
                    rows_wr_q <= rows_wr_q + RW'(1);
            end
        end
    end
endmodule
